// File: rtl/transmisor_paquete_mouse.sv
// PS/2 mouse packet transmitter: three 11-bit frames per Enviar, device-driven Ps2Clk.
// Optional TX_MOUSE_SATURAR_EN clamps deltas to 9-bit signed and flags overflow in byte0.
module transmisor_paquete_mouse #(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Enviar,
    input  logic [9:0] DeltaX,
    input  logic [9:0] DeltaY,
    input  logic [2:0] Botones,
    input  logic       Inhibir,
    output logic       Ps2Clk,
    output logic       Ps2Data,
    output logic       Ocupado,
    output logic       Listo
);
    localparam int CMAX = (2*HALF_PERIOD > GAP_CYCLES) ? 2*HALF_PERIOD : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] C_BIT  = CW'(2*HALF_PERIOD - 1);
    localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [7:0]    r_b0, r_b1, r_b2;

    logic [8:0] w_x9, w_y9;
    logic       w_xovf, w_yovf;
    logic [7:0] w_byte0, w_cur;

`ifdef TX_MOUSE_SATURAR_EN
    // Out of 9-bit range exactly when the two top bits of the 10-bit delta differ.
    assign w_xovf = DeltaX[9] ^ DeltaX[8];
    assign w_yovf = DeltaY[9] ^ DeltaY[8];
    assign w_x9   = w_xovf ? (DeltaX[9] ? 9'h100 : 9'h0FF) : DeltaX[8:0];
    assign w_y9   = w_yovf ? (DeltaY[9] ? 9'h100 : 9'h0FF) : DeltaY[8:0];
`else
    assign w_xovf = 1'b0;
    assign w_yovf = 1'b0;
    assign w_x9   = DeltaX[8:0];
    assign w_y9   = DeltaY[8:0];
`endif

    assign w_byte0 = {w_yovf, w_xovf, w_y9[8], w_x9[8], 1'b1, Botones};

    always_comb begin
        w_cur = r_b0;
        case (r_byte)
            2'd1:    w_cur = r_b1;
            2'd2:    w_cur = r_b2;
            default: w_cur = r_b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
            Ps2Clk  <= 1'b1;
            Ps2Data <= 1'b1;
            Ocupado <= 1'b0;
            Listo   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    Ps2Clk  <= 1'b1;
                    Ps2Data <= 1'b1;
                    Ocupado <= 1'b0;
                    Listo   <= 1'b0;
                    if (Enviar && !Inhibir) begin
                        r_b0    <= w_byte0;
                        r_b1    <= w_x9[7:0];
                        r_b2    <= w_y9[7:0];
                        r_byte  <= 2'd0;
                        r_cyc   <= '0;
                        r_state <= START;
                        Ps2Data <= 1'b0;
                        Ocupado <= 1'b1;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    if (r_cyc == C_HALF) Ps2Clk <= 1'b0;
                    if (r_cyc != C_BIT) begin
                        r_cyc <= r_cyc + 1'b1;
                    end else begin
                        // Bit boundary: the only point where host inhibit is honoured.
                        r_cyc  <= '0;
                        Ps2Clk <= 1'b1;
                        if (Inhibir) begin
                            r_state <= IDLE;
                            Ps2Data <= 1'b1;
                            Ocupado <= 1'b0;
                        end else begin
                            case (r_state)
                                START: begin
                                    r_state <= DATA;
                                    r_bit   <= 3'd0;
                                    Ps2Data <= w_cur[0];
                                end
                                DATA: begin
                                    if (r_bit == 3'd7) begin
                                        r_state <= PARITY;
                                        Ps2Data <= ~^w_cur;
                                    end else begin
                                        r_bit   <= r_bit + 3'd1;
                                        Ps2Data <= w_cur[r_bit + 3'd1];
                                    end
                                end
                                PARITY: begin
                                    r_state <= STOP;
                                    Ps2Data <= 1'b1;
                                end
                                default: begin
                                    r_state <= GAP;
                                    Ps2Data <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                GAP: begin
                    Ps2Clk  <= 1'b1;
                    Ps2Data <= 1'b1;
                    if (r_cyc != C_GAP) begin
                        r_cyc <= r_cyc + 1'b1;
                    end else begin
                        r_cyc <= '0;
                        if (r_byte == 2'd2) begin
                            r_state <= DONE;
                            Ocupado <= 1'b0;
                            Listo   <= 1'b1;
                        end else begin
                            r_byte  <= r_byte + 2'd1;
                            r_state <= START;
                            Ps2Data <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    Listo   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_transmisor_paquete_mouse.sv
// Scoreboard bench: expected bytes queued at Enviar, a PS/2 frame monitor pops and compares.
module tb_transmisor_paquete_mouse;
    localparam int HP  = 4;
    localparam int GAP = 8;
    localparam int PKT = 3*(22*HP) + 3*GAP;   // acceptance edge to Listo

    logic       clk = 1'b0;
    logic       rst;
    logic       Enviar;
    logic [9:0] DeltaX, DeltaY;
    logic [2:0] Botones;
    logic       Inhibir;
    logic       Ps2Clk, Ps2Data, Ocupado, Listo;

    transmisor_paquete_mouse #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .Enviar(Enviar), .DeltaX(DeltaX), .DeltaY(DeltaY),
        .Botones(Botones), .Inhibir(Inhibir), .Ps2Clk(Ps2Clk), .Ps2Data(Ps2Data),
        .Ocupado(Ocupado), .Listo(Listo)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    int listo_cnt = 0;
    int t0 = 0;
    logic [7:0] exp_q[$];

    // Reference packet encoding, written in integer arithmetic.
    function automatic void model(input logic signed [9:0] dx, input logic signed [9:0] dy,
                                  input logic [2:0] btn, output logic [7:0] b0,
                                  output logic [7:0] b1, output logic [7:0] b2);
        int  x, y;
        logic xo, yo;
        x = int'(dx);
        y = int'(dy);
        xo = 1'b0;
        yo = 1'b0;
`ifdef TX_MOUSE_SATURAR_EN
        if (x > 255) begin x = 255; xo = 1'b1; end
        else if (x < -256) begin x = -256; xo = 1'b1; end
        if (y > 255) begin y = 255; yo = 1'b1; end
        else if (y < -256) begin y = -256; yo = 1'b1; end
`endif
        b1 = 8'(x & 255);
        b2 = 8'(y & 255);
        b0 = {yo, xo, ((y & 256) != 0), ((x & 256) != 0), 1'b1, btn};
    endfunction

    // PS/2 monitor: samples data on each Ps2Clk falling edge.
    logic [10:0] rx;
    int          nbits = 0;
    int          last_fall = 0;
    logic        prev_clk = 1'b1;
    always @(negedge clk) begin
        logic [7:0]  eb;
        logic [10:0] ef;
        if (!Ocupado || !rst) begin
            nbits = 0;
        end else if (prev_clk && !Ps2Clk) begin
            if (nbits > 0) begin
                vec++;
                if (cyc - last_fall !== 2*HP) begin
                    errs++;
                    $display("FAIL bit_period: got %0d cycles, want %0d", cyc - last_fall, 2*HP);
                end
            end
            rx[nbits] = Ps2Data;
            nbits++;
            last_fall = cyc;
            if (nbits == 11) begin
                nbits = 0;
                vec++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL frame_unexpected: got %03h, want none", rx);
                end else begin
                    eb = exp_q.pop_front();
                    ef = {1'b1, ~^eb, eb, 1'b0};
                    if (rx !== ef) begin
                        errs++;
                        $display("FAIL frame: got %03h, want %03h (byte %02h)", rx, ef, eb);
                    end
                end
            end
        end
        prev_clk = Ps2Clk;
        if (Listo === 1'b1) listo_cnt++;
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load(input logic signed [9:0] dx, input logic signed [9:0] dy,
                        input logic [2:0] btn);
        logic [7:0] b0, b1, b2;
        model(dx, dy, btn, b0, b1, b2);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        DeltaX = dx; DeltaY = dy; Botones = btn;
    endtask

    // Pulses Enviar and checks the start bit appears right after the accepting edge.
    task automatic send(input logic signed [9:0] dx, input logic signed [9:0] dy,
                        input logic [2:0] btn);
        load(dx, dy, btn);
        Enviar = 1'b1;
        tick(1);
        Enviar = 1'b0;
        t0 = cyc;
        vec++;
        if ({Ocupado, Ps2Clk, Ps2Data} !== 3'b110) begin
            errs++;
            $display("FAIL accept: got ocupado/clk/data %b, want 110", {Ocupado, Ps2Clk, Ps2Data});
        end
    endtask

    task automatic wait_listo(output int elapsed);
        int n;
        n = 0;
        while (Listo !== 1'b1 && n < 1000) begin tick(1); n++; end
        elapsed = cyc - t0;
        vec++;
        if (Listo !== 1'b1) begin
            errs++;
            $display("FAIL listo_timeout: got no Listo, want Listo within 1000 cycles");
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; Enviar = 1'b1; Inhibir = 1'b0;
        DeltaX = 10'd7; DeltaY = 10'd7; Botones = 3'b111;
        tick(3);
        vec++;
        if ({Ps2Clk, Ps2Data, Ocupado, Listo} !== 4'b1100) begin
            errs++;
            $display("FAIL reset_outputs: got %b, want 1100", {Ps2Clk, Ps2Data, Ocupado, Listo});
        end
        Enviar = 1'b0; rst = 1'b1;
        tick(2);
        vec++;
        if (Ocupado !== 1'b0) begin
            errs++;
            $display("FAIL reset_priority: got Ocupado %b, want 0", Ocupado);
        end
    endtask

    task automatic test_basic;
        int e;
        send(10'sd5, -10'sd3, 3'b001);
        wait_listo(e);
        vec++;
        if (e !== PKT) begin
            errs++;
            $display("FAIL packet_length: got %0d, want %0d", e, PKT);
        end
        vec++;
        if (Ocupado !== 1'b0) begin
            errs++;
            $display("FAIL done_ocupado: got %b, want 0", Ocupado);
        end
        tick(1);
        vec++;
        if (Listo !== 1'b0) begin
            errs++;
            $display("FAIL listo_width: got %b, want 0", Listo);
        end
    endtask

    task automatic test_saturation;
        int e;
        send(10'sd300, 10'sd0, 3'b000);
        wait_listo(e);
        tick(2);
        send(-10'sd300, 10'sd255, 3'b110);
        wait_listo(e);
        tick(2);
        send(-10'sd256, -10'sd257, 3'b010);
        wait_listo(e);
        tick(2);
    endtask

    task automatic test_back_to_back;
        int e, lc;
        lc = listo_cnt;
        send(10'sd100, -10'sd100, 3'b100);
        tick(110);
        DeltaX = 10'd1; DeltaY = 10'd2; Botones = 3'b011;
        Enviar = 1'b1;
        tick(1);
        Enviar = 1'b0;
        wait_listo(e);
        vec++;
        if (e !== PKT) begin
            errs++;
            $display("FAIL b2b_length: got %0d, want %0d", e, PKT);
        end
        tick(40);
        vec++;
        if (listo_cnt - lc !== 1 || Ocupado !== 1'b0) begin
            errs++;
            $display("FAIL b2b_listo: got %0d pulses ocupado %b, want 1 pulse ocupado 0",
                     listo_cnt - lc, Ocupado);
        end
    endtask

    task automatic test_inhibit;
        int e, lc, n;
        lc = listo_cnt;
        send(10'sd9, 10'sd12, 3'b101);
        while (cyc - t0 < 128) tick(1);
        Inhibir = 1'b1;
        n = 0;
        while (Ocupado === 1'b1 && n < 40) begin tick(1); n++; end
        vec++;
        if (cyc - t0 !== 136 || {Ps2Clk, Ps2Data, Ocupado, Listo} !== 4'b1100) begin
            errs++;
            $display("FAIL inhibit_abort: got t=%0d lines %b, want t=136 lines 1100",
                     cyc - t0, {Ps2Clk, Ps2Data, Ocupado, Listo});
        end
        exp_q.delete();
        Enviar = 1'b1;
        tick(1);
        Enviar = 1'b0;
        vec++;
        if (Ocupado !== 1'b0) begin
            errs++;
            $display("FAIL inhibit_idle: got Ocupado %b, want 0", Ocupado);
        end
        tick(3);
        vec++;
        if (listo_cnt !== lc) begin
            errs++;
            $display("FAIL inhibit_listo: got %0d pulses, want 0", listo_cnt - lc);
        end
        Inhibir = 1'b0;
        tick(1);
        send(-10'sd1, 10'sd1, 3'b010);
        wait_listo(e);
        tick(2);
    endtask

    task automatic test_reset_gap;
        int lc;
        lc = listo_cnt;
        send(10'sd33, 10'sd44, 3'b001);
        while (cyc - t0 < 90) tick(1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        vec++;
        if ({Ps2Clk, Ps2Data, Ocupado, Listo} !== 4'b1100) begin
            errs++;
            $display("FAIL reset_gap: got %b, want 1100", {Ps2Clk, Ps2Data, Ocupado, Listo});
        end
        exp_q.delete();
        tick(300);
        vec++;
        if (listo_cnt !== lc || Ocupado !== 1'b0) begin
            errs++;
            $display("FAIL reset_gap_listo: got %0d pulses ocupado %b, want 0 pulses ocupado 0",
                     listo_cnt - lc, Ocupado);
        end
    endtask

    task automatic test_done_enviar;
        int e;
        send(10'sd7, 10'sd8, 3'b000);
        wait_listo(e);
        load(10'sd64, -10'sd64, 3'b111);
        Enviar = 1'b1;
        tick(1);
        vec++;
        if (Ocupado !== 1'b0) begin
            errs++;
            $display("FAIL done_enviar: got Ocupado %b, want 0", Ocupado);
        end
        tick(1);
        Enviar = 1'b0;
        t0 = cyc;
        vec++;
        if ({Ocupado, Ps2Data} !== 2'b10) begin
            errs++;
            $display("FAIL idle_accept: got ocupado/data %b, want 10", {Ocupado, Ps2Data});
        end
        wait_listo(e);
        tick(2);
    endtask

    initial begin
        rst = 1'b0; Enviar = 1'b0; Inhibir = 1'b0;
        DeltaX = '0; DeltaY = '0; Botones = '0;
        test_reset;
        test_basic;
        test_saturation;
        test_back_to_back;
        test_inhibit;
        test_reset_gap;
        test_done_enviar;
        tick(5);
        vec++;
        if (exp_q.size() !== 0) begin
            errs++;
            $display("FAIL missing_frames: got %0d bytes pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
